// File: rtl/cordic_vectoring_iter_pkg.sv
// Shared constants for the vectoring-mode CORDIC: binary-angle scale, arctangent
// table, FSM encoding and the uncompensated gain.
package cordic_pkg;

    localparam int  DATA_WIDTH_DEF = 18;
    localparam int  ANGLE_PI       = 2 ** (DATA_WIDTH_DEF - 1);
    localparam real CORDIC_GAIN    = 1.64676;

    // Reference table is round(atan(2^-i)/pi * 2^17); other widths are rescaled from it.
    localparam int ATAN_REF_W = 18;
    localparam int ATAN_DEPTH = 32;
    localparam logic [31:0] ATAN_REF [ATAN_DEPTH] = '{
        32'd32768, 32'd19344, 32'd10221, 32'd5188, 32'd2604, 32'd1303, 32'd652, 32'd326,
        32'd163,   32'd81,    32'd41,    32'd20,   32'd10,   32'd5,    32'd3,   32'd1,
        32'd1,     32'd0,     32'd0,     32'd0,    32'd0,    32'd0,    32'd0,   32'd0,
        32'd0,     32'd0,     32'd0,     32'd0,    32'd0,    32'd0,    32'd0,   32'd0
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_DONE   = 2'd2
    } cordic_state_e;

    function automatic logic [31:0] atan_entry(input logic [4:0] idx, input int dw);
        logic [31:0] ref_v;
        ref_v = ATAN_REF[idx];
        if (dw >= ATAN_REF_W) begin
            atan_entry = ref_v << (dw - ATAN_REF_W);
        end else begin
            atan_entry = (ref_v + (32'd1 << (ATAN_REF_W - 1 - dw))) >> (ATAN_REF_W - dw);
        end
    endfunction

endpackage

// File: rtl/cordic_vectoring_iter_if.sv
// Operand/result handshake bundle between the sample front end, the CORDIC and its consumer.
interface cordic_vectoring_iter_if #(
    parameter int DATA_WIDTH = 18
);
    logic signed [DATA_WIDTH-1:0] in_x;
    logic signed [DATA_WIDTH-1:0] in_y;
    logic                         valid_in;
    logic                         in_ready;
    logic        [DATA_WIDTH:0]   out_mag;
    logic signed [DATA_WIDTH-1:0] out_phase;
    logic                         valid_out;
    logic                         out_ready;

    modport master (
        output in_x, in_y, valid_in, out_ready,
        input  in_ready, out_mag, out_phase, valid_out
    );

    modport slave (
        input  in_x, in_y, valid_in, out_ready,
        output in_ready, out_mag, out_phase, valid_out
    );
endinterface

// File: rtl/cordic_vectoring_iter_stage.sv
// One combinational vectoring micro-rotation; steers toward y = 0 and accumulates angle in z.
module cordic_vec_stage #(
    parameter int XW = 20,
    parameter int ZW = 18,
    parameter int SW = 5
) (
    input  logic signed [XW-1:0] x,
    input  logic signed [XW-1:0] y,
    input  logic        [ZW-1:0] z,
    input  logic        [SW-1:0] shift,
    input  logic        [ZW-1:0] atan,
    output logic signed [XW-1:0] x_nxt,
    output logic signed [XW-1:0] y_nxt,
    output logic        [ZW-1:0] z_nxt
);

    logic signed [XW-1:0] x_sh_s;
    logic signed [XW-1:0] y_sh_s;

    assign x_sh_s = x >>> shift;
    assign y_sh_s = y >>> shift;

    // Rotate clockwise when y is non-negative, counter-clockwise otherwise; z wraps freely.
    always_comb begin
        x_nxt = x;
        y_nxt = y;
        z_nxt = z;
        if (y[XW-1] == 1'b0) begin
            x_nxt = x + y_sh_s;
            y_nxt = y - x_sh_s;
            z_nxt = z + atan;
        end else begin
            x_nxt = x - y_sh_s;
            y_nxt = y + x_sh_s;
            z_nxt = z - atan;
        end
    end

endmodule

// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring CORDIC: (x, y) in, gain-scaled magnitude and binary-angle atan2 out,
// one micro-rotation per clock through a single shared stage.
module cordic_vectoring_iter
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int N_ITER     = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    cordic_vectoring_iter_if.slave bus
);

    localparam int XW = DATA_WIDTH + 2;
    localparam int SW = 5;

    cordic_state_e            state_r;
    cordic_state_e            state_nxt_s;
    logic signed [XW-1:0]     x_r;
    logic signed [XW-1:0]     y_r;
    logic [DATA_WIDTH-1:0]    z_r;
    logic [SW-1:0]            iter_r;
    logic [DATA_WIDTH:0]      out_mag_r;
    logic [DATA_WIDTH-1:0]    out_phase_r;
    logic                     valid_out_r;

    logic signed [XW-1:0]     x_ext_s;
    logic signed [XW-1:0]     y_ext_s;
    logic signed [XW-1:0]     x_nxt_s;
    logic signed [XW-1:0]     y_nxt_s;
    logic [DATA_WIDTH-1:0]    z_nxt_s;
    logic [DATA_WIDTH-1:0]    atan_s;
    logic [DATA_WIDTH:0]      mag_s;
    logic                     last_s;

    assign x_ext_s = {{2{bus.in_x[DATA_WIDTH-1]}}, bus.in_x};
    assign y_ext_s = {{2{bus.in_y[DATA_WIDTH-1]}}, bus.in_y};
    assign atan_s  = DATA_WIDTH'(atan_entry(iter_r, DATA_WIDTH));
    assign last_s  = (iter_r == SW'(N_ITER - 1));

    cordic_vec_stage #(
        .XW (XW),
        .ZW (DATA_WIDTH),
        .SW (SW)
    ) u_stage (
        .x     (x_r),
        .y     (y_r),
        .z     (z_r),
        .shift (iter_r),
        .atan  (atan_s),
        .x_nxt (x_nxt_s),
        .y_nxt (y_nxt_s),
        .z_nxt (z_nxt_s)
    );

    // Magnitude from the final x, clamped so a slightly negative residue never wraps large.
    always_comb begin
        mag_s = '0;
        if (x_nxt_s[XW-1] == 1'b1) begin
            mag_s = '0;
        end else begin
            mag_s = x_nxt_s[DATA_WIDTH:0];
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.valid_in) begin
                    state_nxt_s = ST_ROTATE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ROTATE: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ROTATE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath: pre-rotate into the right half-plane on load, iterate, then publish and hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_r         <= '0;
            y_r         <= '0;
            z_r         <= '0;
            iter_r      <= '0;
            out_mag_r   <= '0;
            out_phase_r <= '0;
            valid_out_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.valid_in) begin
                        if (bus.in_x[DATA_WIDTH-1] == 1'b0) begin
                            x_r <= x_ext_s;
                            y_r <= y_ext_s;
                            z_r <= '0;
                        end else begin
                            x_r <= -x_ext_s;
                            y_r <= -y_ext_s;
                            z_r <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
                        end
                        iter_r <= '0;
                    end
                end
                ST_ROTATE: begin
                    x_r    <= x_nxt_s;
                    y_r    <= y_nxt_s;
                    z_r    <= z_nxt_s;
                    iter_r <= iter_r + SW'(1);
                    if (last_s) begin
                        out_mag_r   <= mag_s;
                        out_phase_r <= z_nxt_s;
                        valid_out_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        valid_out_r <= 1'b0;
                    end
                end
                default: valid_out_r <= 1'b0;
            endcase
        end
    end

    assign bus.in_ready  = (state_r == ST_IDLE);
    assign bus.out_mag   = out_mag_r;
    assign bus.out_phase = out_phase_r;
    assign bus.valid_out = valid_out_r;

endmodule
